// File: rtl/eth_tx_arb_pkg.sv
// Shared types, constants and the round-robin helper for the MAC TX frame arbiter.
package eth_tx_arb_pkg;

    localparam int unsigned S_MAX     = 16;
    localparam int unsigned IDX_MAX_W = 4;

    localparam logic [7:0] ABORT_TDATA = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ABORT  = 2'd2,
        DROP   = 2'd3
    } arb_state_e;

    // First requesting port after 'last', wrapping modulo n; returns 'last' when nobody requests.
    function automatic logic [IDX_MAX_W-1:0] rr_next(
        input logic [S_MAX-1:0]     req,
        input logic [IDX_MAX_W-1:0] last,
        input int unsigned          n
    );
        logic [IDX_MAX_W-1:0] pick;
        logic                 hit;
        int unsigned          idx;
        pick = last;
        hit  = 1'b0;
        for (int unsigned i = 1; i <= S_MAX; i++) begin
            idx = (32'(last) + i) % n;
            if (!hit && (i <= n) && req[idx[IDX_MAX_W-1:0]]) begin
                pick = IDX_MAX_W'(idx);
                hit  = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/eth_rr_pick.sv
// Combinational round-robin picker: next requesting port after the last grant.
module eth_rr_pick
    import eth_tx_arb_pkg::*;
#(
    parameter int unsigned S_COUNT = 4,
    localparam int unsigned CL_S = $clog2(S_COUNT)
) (
    input  logic [S_COUNT-1:0] req,
    input  logic [CL_S-1:0]    last,
    output logic [CL_S-1:0]    idx,
    output logic               found
);

    assign found = |req;
    assign idx   = CL_S'(rr_next(S_MAX'(req), IDX_MAX_W'(last), S_COUNT));

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter in front of the MAC TX stream, with a
// mid-frame stall watchdog that closes a dead frame with an errored beat.
module eth_tx_frame_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int unsigned S_COUNT       = 4,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned STALL_TIMEOUT = 1024,
    localparam int unsigned CL_S = $clog2(S_COUNT)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT-1:0]            s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    output logic                          grant_valid,
    output logic [CL_S-1:0]               grant_index,
    output logic                          stall_abort
);

    localparam int unsigned CNT_W = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;

    arb_state_e             state;
    arb_state_e             state_nxt;
    logic [CL_S-1:0]        last_grant;
    logic [CL_S-1:0]        pick_idx;
    logic                   pick_found;
    logic [CNT_W-1:0]       stall_cnt;
    logic                   stall_hit;
    logic                   src_tvalid;
    logic                   src_tlast;
    logic                   src_tuser;
    logic [DATA_WIDTH-1:0]  src_tdata;

    assign src_tvalid = s_axis_tvalid[grant_index];
    assign src_tlast  = s_axis_tlast[grant_index];
    assign src_tuser  = s_axis_tuser[grant_index];
    assign src_tdata  = s_axis_tdata[DATA_WIDTH*grant_index +: DATA_WIDTH];
    assign stall_hit  = (STALL_TIMEOUT != 0) && (stall_cnt == CNT_W'(STALL_TIMEOUT));

    eth_rr_pick #(
        .S_COUNT (S_COUNT)
    ) u_pick (
        .req   (s_axis_tvalid),
        .last  (last_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant bookkeeping, stall counter and abort pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_index <= '0;
            last_grant  <= CL_S'(S_COUNT - 1);
            stall_cnt   <= '0;
            stall_abort <= 1'b0;
        end else begin
            stall_abort <= (state == ABORT) && m_axis_tready;
            if ((state == IDLE) && pick_found) begin
                grant_index <= pick_idx;
                last_grant  <= pick_idx;
            end
            if (state != ACTIVE) begin
                stall_cnt <= '0;
            end else if (src_tvalid) begin
                stall_cnt <= '0;
            end else if (stall_cnt != CNT_W'(STALL_TIMEOUT)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    // A tlast accepted on the same cycle as the stall limit closes the frame normally.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_found) state_nxt = ACTIVE;
            ACTIVE: begin
                if (src_tvalid && m_axis_tready && src_tlast) state_nxt = IDLE;
                else if (stall_hit)                            state_nxt = ABORT;
            end
            ABORT:   if (m_axis_tready) state_nxt = DROP;
            DROP:    if (src_tvalid && src_tlast) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        grant_valid   = (state != IDLE);
        case (state)
            ACTIVE: begin
                m_axis_tdata               = src_tdata;
                m_axis_tvalid              = src_tvalid;
                m_axis_tlast               = src_tlast;
                m_axis_tuser               = src_tuser;
                s_axis_tready[grant_index] = m_axis_tready;
            end
            ABORT: begin
                m_axis_tdata  = DATA_WIDTH'(ABORT_TDATA);
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tuser  = 1'b1;
            end
            DROP:    s_axis_tready[grant_index] = 1'b1;
            default: ;
        endcase
    end

endmodule
